flag_seq_detector: RTL
======================

Name: flag_seq_detector

Overview:
- Downstream consumer of the registered flag stream Q from the combinational-flag + DFF system stage.
- Samples that 1-bit flag once per enabled clock and detects the overlapping serial pattern 1-1-0-1.
- Counts detections and tracks run lengths of consecutive 1s.
- Outputs are all registered; they drive status/interrupt logic further downstream.

Parameters:
- CW, 8: width of detection counter Count; saturates at 2^CW-1.
- RW, 4: width of run-length outputs Run and MaxRun; saturate at 2^RW-1.

Ports:
- Clk  input  1  system clock; all state changes on posedge.
- Rst  input  1  asynchronous, active-high reset.
- Din  input  1  flag stream, connected to System Q.
- En  input  1  sample enable; Din is consumed only on edges where En=1.
- Clr  input  1  synchronous clear of state and statistics.
- Det  output  1  one-cycle detection pulse, registered.
- Count  output  CW  number of detections since reset/clear, saturating.
- Run  output  RW  length of the current run of sampled 1s, saturating.
- MaxRun  output  RW  longest run seen since reset/clear, saturating.

Behaviour:
- Reset is asynchronous and active-high on Rst. While Rst=1: state=S0, Det=0, Count=0, Run=0, MaxRun=0, immediately and independently of Clk.
- Rst deassertion: the first enabled posedge after Rst falls samples Din normally.
- Priority on each posedge: Rst > Clr > En.
- Clr=1 at a posedge: state=S0, Det=0, Count=0, Run=0, MaxRun=0. Din is ignored on that edge.
- En=0, Clr=0 at a posedge: state, Count, Run and MaxRun hold; Det=0.
- FSM (Moore-coded state, registered pulse output), transitions on enabled edges:
  - S0 (nothing matched): Din=1 -> S1; Din=0 -> S0.
  - S1 (seen 1): Din=1 -> S2; Din=0 -> S0.
  - S2 (seen 11): Din=1 -> S2; Din=0 -> S3.
  - S3 (seen 110): Din=1 -> S1 and detect; Din=0 -> S0.
- Overlap: the trailing 1 of a match seeds the next match. Example: 1101101 yields 2 detections.
- Det latency: Det=1 for exactly one cycle, following the enabled edge that samples the final 1. Det=0 otherwise, including on any held cycle.
- Count: increments by 1 on each detect edge. At 2^CW-1 it holds; no wrap.
- Run, on an enabled edge:
  - Din=1: Run <= Run+1, saturating at 2^RW-1.
  - Din=0: Run <= 0.
- MaxRun: on an enabled edge, MaxRun <= max(MaxRun, next Run value). MaxRun therefore reflects the run including the current sample in the same cycle Run updates.
- Din is assumed synchronous to Clk, since it comes from a DFF on the same clock. No synchronizer is required.
- Rst asserted mid-pattern: partial match is discarded. An asynchronous Rst that overlaps a Det cycle forces Det low immediately.
- Widths: all arithmetic is unsigned. Saturation compare is against the all-ones constant of the respective width.

Test Plan:
- Reset: Rst=1 for 2 cycles with Din toggling -> Det=0, Count=0, Run=0, MaxRun=0 throughout. Assert Rst mid-cycle -> outputs clear before the next edge.
- Overlap detection: En=1, Din sequence 1,1,0,1,1,0,1 on consecutive edges -> Det pulses after the 4th and 7th edges, Count=2. Run ends at 1; MaxRun=2.
- Enable hold: Din 1,1, then En=0 for 3 cycles with Din=0, then En=1 with Din 0,1 -> single Det after the last edge, Count=1. Run/MaxRun unchanged during the En=0 window.
- Saturation: CW=2 (test override), 5 back-to-back 1101 matches with overlap -> Count reaches 3 and holds. Run: 20 consecutive 1s with RW=4 -> Run=15, MaxRun=15, no wrap.
- Clear vs enable: pattern 1,1,0 then Clr=1 with En=1 and Din=1 on the same edge -> no Det, state S0, Count=0. A following Din=1 leaves the FSM in S1, not a detect.
- End-to-end: System driven with In=1100,0000,0001,0000,1011 (Q=1,0,1,0,1 after one cycle each) into this block -> Det=0 (sequence 10101 has no 1101), MaxRun=1.

Source files
------------

// File: rtl/flag_seq_detector.sv
// Detects the overlapping serial pattern 1-1-0-1 on a sampled flag stream.
// It also counts detections and tracks the current and longest runs of 1s.
module flag_seq_detector #(
    parameter int CW = 8,
    parameter int RW = 4
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Din,
    input  logic          En,
    input  logic          Clr,
    output logic          Det,
    output logic [CW-1:0] Count,
    output logic [RW-1:0] Run,
    output logic [RW-1:0] MaxRun
);

    typedef enum logic [1:0] {
        S0,
        S1,
        S2,
        S3
    } state_t;

    state_t        state_reg;
    logic [RW-1:0] run_next;

    // Run value after the current sample; MaxRun is compared against this
    // value so that it updates in the same cycle as Run.
    always_comb begin
        run_next = '0;
        if (Din) begin
            run_next = (Run == '1) ? Run : Run + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_reg <= S0;
            Det       <= 1'b0;
            Count     <= '0;
            Run       <= '0;
            MaxRun    <= '0;
        end else if (Clr) begin
            state_reg <= S0;
            Det       <= 1'b0;
            Count     <= '0;
            Run       <= '0;
            MaxRun    <= '0;
        end else if (En) begin
            Det <= 1'b0;
            case (state_reg)
                S0: state_reg <= Din ? S1 : S0;
                S1: state_reg <= Din ? S2 : S0;
                S2: state_reg <= Din ? S2 : S3;
                S3: begin
                    if (Din) begin
                        // The trailing 1 of this match seeds the next match.
                        state_reg <= S1;
                        Det       <= 1'b1;
                        if (Count != '1) begin
                            Count <= Count + 1'b1;
                        end
                    end else begin
                        state_reg <= S0;
                    end
                end
                default: state_reg <= S0;
            endcase
            Run <= run_next;
            if (run_next > MaxRun) begin
                MaxRun <= run_next;
            end
        end else begin
            Det <= 1'b0;
        end
    end

endmodule
